// File: rtl/move_test_sequencer_pkg.sv
// Shared constants and types for the move test sequencer: pose widths,
// request encoding, FSM states and the wall-kick dx table.
package move_test_sequencer_pkg;

  localparam int X_BITS    = 4;
  localparam int Y_BITS    = 5;
  localparam int ROT_BITS  = 2;
  localparam int NUM_REQ   = 5;
  localparam int KICK_BITS = 2;

  // Request index doubles as the priority rank (0 = highest).
  typedef enum logic [2:0] {
    REQ_DROP    = 3'd0,
    REQ_LEFT    = 3'd1,
    REQ_RIGHT   = 3'd2,
    REQ_ROT_CW  = 3'd3,
    REQ_ROT_CCW = 3'd4
  } req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TEST   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Horizontal kick offset per attempt: 0, -1, +1 (modulo 2^X_BITS).
  function automatic logic [X_BITS-1:0] kick_dx(input logic [KICK_BITS-1:0] idx);
    case (idx)
      2'd1:    kick_dx = '1;
      2'd2:    kick_dx = X_BITS'(1);
      default: kick_dx = '0;
    endcase
  endfunction

  // Convert a one-hot grant vector into the request encoding.
  function automatic req_t grant_to_req(input logic [NUM_REQ-1:0] grant);
    grant_to_req = REQ_DROP;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (grant[i]) grant_to_req = req_t'(i[2:0]);
    end
  endfunction

endpackage

// File: rtl/move_test_sequencer_if.sv
// Test-pose / collision-checker handshake between the sequencer (master)
// and the board collision checker (slave).
interface move_test_sequencer_if;
  import move_test_sequencer_pkg::*;

  logic                test_valid;
  logic [X_BITS-1:0]   test_pos_x;
  logic [Y_BITS-1:0]   test_pos_y;
  logic [ROT_BITS-1:0] test_rot;
  logic                chk_done;
  logic                chk_fit;

  modport master (
    output test_valid, test_pos_x, test_pos_y, test_rot,
    input  chk_done, chk_fit
  );

  modport slave (
    input  test_valid, test_pos_x, test_pos_y, test_rot,
    output chk_done, chk_fit
  );
endinterface

// File: rtl/move_test_sequencer_req_pending.sv
// Pending movement-request flags plus fixed-priority one-hot grant.
// Bit 0 has the highest priority.
module move_req_pending
  import move_test_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_clr_all,
  input  logic               i_take,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_any
);

  logic [NUM_REQ-1:0] r_flag;
  logic [NUM_REQ:0]   w_higher;

  assign w_higher[0] = 1'b0;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_prio
    assign o_grant[gi]    = r_flag[gi] & ~w_higher[gi];
    assign w_higher[gi+1] = w_higher[gi] | r_flag[gi];
  end

  assign o_any = w_higher[NUM_REQ];

  // Flags: clear-all wins (drops coincident pulses); a taken flag is
  // re-set if a new pulse lands on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_flag <= '0;
    else if (i_clr_all) r_flag <= '0;
    else                r_flag <= (r_flag & ~(i_take ? o_grant : '0)) | i_req;
  end

endmodule

// File: rtl/move_test_sequencer.sv
// Move test sequencer: serialises movement requests into test poses for the
// collision checker and commits fitting poses.
// Optional feature macro: WALL_KICK_EN (rotate retries with dx 0,-1,+1).
module move_test_sequencer
  import move_test_sequencer_pkg::*;
#(
  parameter int NUM_KICKS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_play_en,
  input  logic                  i_spawn,
  input  logic [X_BITS-1:0]     i_spawn_x,
  input  logic [Y_BITS-1:0]     i_spawn_y,
  input  logic                  i_drop_tick,
  input  logic                  i_req_left,
  input  logic                  i_req_right,
  input  logic                  i_req_rot_cw,
  input  logic                  i_req_rot_ccw,
  move_test_sequencer_if.master chk,
  output logic [X_BITS-1:0]     o_cur_pos_x,
  output logic [Y_BITS-1:0]     o_cur_pos_y,
  output logic [ROT_BITS-1:0]   o_cur_rot,
  output logic                  o_lock_pulse,
  output logic                  o_busy
);

  state_t              r_state, w_state_next;
  req_t                r_req, w_sel_req;
  logic [X_BITS-1:0]   r_cur_x, r_test_x, w_next_x;
  logic [Y_BITS-1:0]   r_cur_y, r_test_y, w_next_y;
  logic [ROT_BITS-1:0] r_cur_rot, r_test_rot, w_next_rot;
  logic                r_lock;
  logic [NUM_REQ-1:0]  w_req, w_grant;
  logic                w_any, w_take, w_commit, w_lock, w_kick_inc;
  logic                w_kick_more, w_reissue, w_test_valid, w_clr_all;

  assign w_req     = {i_req_rot_ccw, i_req_rot_cw, i_req_right, i_req_left, i_drop_tick};
  assign w_clr_all = i_spawn | ~i_play_en;

  move_req_pending u_pending (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (w_req),
    .i_clr_all (w_clr_all),
    .i_take    (w_take),
    .o_grant   (w_grant),
    .o_any     (w_any)
  );

`ifdef WALL_KICK_EN
  localparam logic [KICK_BITS-1:0] KICK_LAST = KICK_BITS'(NUM_KICKS - 1);
  logic [KICK_BITS-1:0] r_kick;
  logic                 r_reissue;
  logic [X_BITS-1:0]    w_kick_x;

  assign w_kick_more = ((r_req == REQ_ROT_CW) || (r_req == REQ_ROT_CCW)) && (r_kick < KICK_LAST);
  assign w_kick_x    = r_cur_x + kick_dx(r_kick + 2'd1);
  assign w_reissue   = r_reissue;

  // Kick attempt counter; re-issue gap holds test_valid low one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kick    <= '0;
      r_reissue <= 1'b0;
    end else begin
      r_reissue <= w_kick_inc;
      if (i_spawn || w_take) r_kick <= '0;
      else if (w_kick_inc)   r_kick <= r_kick + 2'd1;
    end
  end
`else
  assign w_kick_more = 1'b0;
  assign w_reissue   = 1'b0;
`endif

  // A checker result is only accepted while the pose is actually offered.
  assign w_test_valid = (r_state == TEST) && !w_reissue && i_play_en;

  // Priority select and test-pose arithmetic (wraps modulo 2^width).
  always_comb begin
    w_sel_req  = grant_to_req(w_grant);
    w_next_x   = r_cur_x;
    w_next_y   = r_cur_y;
    w_next_rot = r_cur_rot;
    case (w_sel_req)
      REQ_DROP:    w_next_y   = r_cur_y + Y_BITS'(1);
      REQ_LEFT:    w_next_x   = r_cur_x - X_BITS'(1);
      REQ_RIGHT:   w_next_x   = r_cur_x + X_BITS'(1);
      REQ_ROT_CW:  w_next_rot = r_cur_rot + ROT_BITS'(1);
      REQ_ROT_CCW: w_next_rot = r_cur_rot - ROT_BITS'(1);
      default:     ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next state and control strobes; spawn / play disable override all.
  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_commit     = 1'b0;
    w_lock       = 1'b0;
    w_kick_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_take       = 1'b1;
          w_state_next = TEST;
        end
      end
      TEST: begin
        if (w_test_valid && chk.chk_done) begin
          if (chk.chk_fit) begin
            w_commit     = 1'b1;
            w_state_next = COMMIT;
          end else if (r_req == REQ_DROP) begin
            w_lock       = 1'b1;
            w_state_next = IDLE;
          end else if (w_kick_more) begin
            w_kick_inc   = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      COMMIT:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (w_clr_all) begin
      w_state_next = IDLE;
      w_take       = 1'b0;
      w_commit     = 1'b0;
      w_lock       = 1'b0;
      w_kick_inc   = 1'b0;
    end
  end

  // Pose datapath: the fit is committed on the edge that accepts it, so
  // COMMIT is only a one-cycle settle before returning to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_x    <= '0;
      r_cur_y    <= '0;
      r_cur_rot  <= '0;
      r_test_x   <= '0;
      r_test_y   <= '0;
      r_test_rot <= '0;
      r_req      <= REQ_DROP;
      r_lock     <= 1'b0;
    end else if (i_spawn) begin
      r_cur_x   <= i_spawn_x;
      r_cur_y   <= i_spawn_y;
      r_cur_rot <= '0;
      r_lock    <= 1'b0;
    end else begin
      r_lock <= w_lock;
      if (w_take) begin
        r_req      <= w_sel_req;
        r_test_x   <= w_next_x;
        r_test_y   <= w_next_y;
        r_test_rot <= w_next_rot;
      end
`ifdef WALL_KICK_EN
      else if (w_kick_inc) begin
        r_test_x <= w_kick_x;
      end
`endif
      if (w_commit) begin
        r_cur_x   <= r_test_x;
        r_cur_y   <= r_test_y;
        r_cur_rot <= r_test_rot;
      end
    end
  end

  assign chk.test_valid = w_test_valid;
  assign chk.test_pos_x = r_test_x;
  assign chk.test_pos_y = r_test_y;
  assign chk.test_rot   = r_test_rot;
  assign o_cur_pos_x    = r_cur_x;
  assign o_cur_pos_y    = r_cur_y;
  assign o_cur_rot      = r_cur_rot;
  assign o_lock_pulse   = r_lock;
  assign o_busy         = (r_state != IDLE);

endmodule

// File: tb/tb_move_test_sequencer.sv
// Directed bench for move_test_sequencer; wall-kick expectations follow
// WALL_KICK_EN.
module tb_move_test_sequencer;
  import move_test_sequencer_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                play_en = 1'b0;
  logic                spawn = 1'b0;
  logic [X_BITS-1:0]   spawn_x = '0;
  logic [Y_BITS-1:0]   spawn_y = '0;
  logic                drop_tick = 1'b0;
  logic                req_left = 1'b0;
  logic                req_right = 1'b0;
  logic                req_rot_cw = 1'b0;
  logic                req_rot_ccw = 1'b0;
  logic [X_BITS-1:0]   cur_x;
  logic [Y_BITS-1:0]   cur_y;
  logic [ROT_BITS-1:0] cur_rot;
  logic                lock_pulse;
  logic                busy;
  int                  n_assert = 0;
  int                  n_fail = 0;

  move_test_sequencer_if u_if ();

  move_test_sequencer #(.NUM_KICKS(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_play_en     (play_en),
    .i_spawn       (spawn),
    .i_spawn_x     (spawn_x),
    .i_spawn_y     (spawn_y),
    .i_drop_tick   (drop_tick),
    .i_req_left    (req_left),
    .i_req_right   (req_right),
    .i_req_rot_cw  (req_rot_cw),
    .i_req_rot_ccw (req_rot_ccw),
    .chk           (u_if),
    .o_cur_pos_x   (cur_x),
    .o_cur_pos_y   (cur_y),
    .o_cur_rot     (cur_rot),
    .o_lock_pulse  (lock_pulse),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    $display("check %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic check_pose(input string tag, input logic [X_BITS-1:0] ox, input logic [Y_BITS-1:0] oy,
                            input logic [ROT_BITS-1:0] orot, input logic [X_BITS-1:0] ex,
                            input logic [Y_BITS-1:0] ey, input logic [ROT_BITS-1:0] erot);
    n_assert++;
    assert ({ox, oy, orot} === {ex, ey, erot}) else begin
      n_fail++;
      $error("FAIL %s observed=(%0d,%0d,%0d) expected=(%0d,%0d,%0d)", tag, ox, oy, orot, ex, ey, erot);
    end
    $display("check %s observed=(%0d,%0d,%0d) expected=(%0d,%0d,%0d)", tag, ox, oy, orot, ex, ey, erot);
  endtask

  task automatic do_spawn(input logic [X_BITS-1:0] x, input logic [Y_BITS-1:0] y);
    spawn = 1'b1; spawn_x = x; spawn_y = y;
    tick();
    spawn = 1'b0;
  endtask

  task automatic chk_resp(input logic fit);
    u_if.chk_done = 1'b1; u_if.chk_fit = fit;
    tick();
    u_if.chk_done = 1'b0; u_if.chk_fit = 1'b0;
  endtask

  initial begin
    u_if.chk_done = 1'b0;
    u_if.chk_fit  = 1'b0;
    #12;
    check_pose("reset_cur", cur_x, cur_y, cur_rot, 4'd0, 5'd0, 2'd0);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_valid", u_if.test_valid, 1'b0);
    check_bit("reset_lock", lock_pulse, 1'b0);
    tick();
    rst_n = 1'b1; play_en = 1'b1;

    // 1: spawn, drop, late fit
    do_spawn(4'd4, 5'd0);
    check_pose("t1_spawn", cur_x, cur_y, cur_rot, 4'd4, 5'd0, 2'd0);
    drop_tick = 1'b1; tick(); drop_tick = 1'b0;
    check_bit("t1_valid_lat1", u_if.test_valid, 1'b0);
    tick();
    check_bit("t1_valid_lat2", u_if.test_valid, 1'b1);
    check_pose("t1_test", u_if.test_pos_x, u_if.test_pos_y, u_if.test_rot, 4'd4, 5'd1, 2'd0);
    tick(); tick();
    check_bit("t1_valid_held", u_if.test_valid, 1'b1);
    check_pose("t1_cur_before", cur_x, cur_y, cur_rot, 4'd4, 5'd0, 2'd0);
    chk_resp(1'b1);
    check_pose("t1_cur_commit", cur_x, cur_y, cur_rot, 4'd4, 5'd1, 2'd0);
    check_bit("t1_lock", lock_pulse, 1'b0);
    check_bit("t1_valid_off", u_if.test_valid, 1'b0);
    tick();
    check_bit("t1_idle", busy, 1'b0);

    // 2: failed drop locks
    do_spawn(4'd4, 5'd20);
    drop_tick = 1'b1; tick(); drop_tick = 1'b0; tick();
    check_pose("t2_test", u_if.test_pos_x, u_if.test_pos_y, u_if.test_rot, 4'd4, 5'd21, 2'd0);
    chk_resp(1'b0);
    check_bit("t2_lock_on", lock_pulse, 1'b1);
    check_bit("t2_busy", busy, 1'b0);
    check_pose("t2_cur", cur_x, cur_y, cur_rot, 4'd4, 5'd20, 2'd0);
    tick();
    check_bit("t2_lock_off", lock_pulse, 1'b0);

    // 3: left and rot_cw together serialise
    do_spawn(4'd4, 5'd5);
    req_left = 1'b1; req_rot_cw = 1'b1; tick(); req_left = 1'b0; req_rot_cw = 1'b0; tick();
    check_pose("t3_test_left", u_if.test_pos_x, u_if.test_pos_y, u_if.test_rot, 4'd3, 5'd5, 2'd0);
    chk_resp(1'b1);
    check_pose("t3_cur_left", cur_x, cur_y, cur_rot, 4'd3, 5'd5, 2'd0);
    tick();
    check_bit("t3_gap", u_if.test_valid, 1'b0);
    tick();
    check_bit("t3_valid_rot", u_if.test_valid, 1'b1);
    check_pose("t3_test_rot", u_if.test_pos_x, u_if.test_pos_y, u_if.test_rot, 4'd3, 5'd5, 2'd1);
    chk_resp(1'b1);
    check_pose("t3_cur_final", cur_x, cur_y, cur_rot, 4'd3, 5'd5, 2'd1);
    tick();

    // 4: rotate at x=0 with kicks
    do_spawn(4'd0, 5'd5);
    req_rot_cw = 1'b1; tick(); req_rot_cw = 1'b0; tick();
    chk_resp(1'b1);
    tick();
    check_pose("t4_setup", cur_x, cur_y, cur_rot, 4'd0, 5'd5, 2'd1);
    req_rot_cw = 1'b1; tick(); req_rot_cw = 1'b0; tick();
    check_pose("t4_try0", u_if.test_pos_x, u_if.test_pos_y, u_if.test_rot, 4'd0, 5'd5, 2'd2);
    chk_resp(1'b0);
`ifdef WALL_KICK_EN
    check_bit("t4_gap1", u_if.test_valid, 1'b0);
    check_bit("t4_busy1", busy, 1'b1);
    tick();
    check_bit("t4_valid1", u_if.test_valid, 1'b1);
    check_pose("t4_try1", u_if.test_pos_x, u_if.test_pos_y, u_if.test_rot, 4'd15, 5'd5, 2'd2);
    chk_resp(1'b0);
    check_bit("t4_gap2", u_if.test_valid, 1'b0);
    tick();
    check_bit("t4_valid2", u_if.test_valid, 1'b1);
    check_pose("t4_try2", u_if.test_pos_x, u_if.test_pos_y, u_if.test_rot, 4'd1, 5'd5, 2'd2);
    chk_resp(1'b1);
    check_pose("t4_cur", cur_x, cur_y, cur_rot, 4'd1, 5'd5, 2'd2);
    tick();
`else
    check_bit("t4_discard_valid", u_if.test_valid, 1'b0);
    check_bit("t4_discard_busy", busy, 1'b0);
    check_pose("t4_cur", cur_x, cur_y, cur_rot, 4'd0, 5'd5, 2'd1);
    tick();
`endif

    // 5: spawn mid-TEST with pending right; late chk_done ignored
    req_left = 1'b1; req_right = 1'b1; tick(); req_left = 1'b0; req_right = 1'b0; tick();
    check_bit("t5_valid", u_if.test_valid, 1'b1);
`ifdef WALL_KICK_EN
    check_pose("t5_test_left", u_if.test_pos_x, u_if.test_pos_y, u_if.test_rot, 4'd0, 5'd5, 2'd2);
`else
    check_pose("t5_test_left_wrap", u_if.test_pos_x, u_if.test_pos_y, u_if.test_rot, 4'd15, 5'd5, 2'd1);
`endif
    do_spawn(4'd4, 5'd0);
    check_bit("t5_valid_drop", u_if.test_valid, 1'b0);
    check_bit("t5_busy", busy, 1'b0);
    check_pose("t5_cur_spawn", cur_x, cur_y, cur_rot, 4'd4, 5'd0, 2'd0);
    chk_resp(1'b1);
    check_pose("t5_cur_late", cur_x, cur_y, cur_rot, 4'd4, 5'd0, 2'd0);
    tick(); tick();
    check_bit("t5_no_pending", u_if.test_valid, 1'b0);

    // 6: async reset mid-TEST, then play disabled
    drop_tick = 1'b1; tick(); drop_tick = 1'b0; tick();
    check_bit("t6_valid", u_if.test_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_pose("t6_rst_cur", cur_x, cur_y, cur_rot, 4'd0, 5'd0, 2'd0);
    check_pose("t6_rst_test", u_if.test_pos_x, u_if.test_pos_y, u_if.test_rot, 4'd0, 5'd0, 2'd0);
    check_bit("t6_rst_valid", u_if.test_valid, 1'b0);
    check_bit("t6_rst_busy", busy, 1'b0);
    check_bit("t6_rst_lock", lock_pulse, 1'b0);
    tick();
    play_en = 1'b0; rst_n = 1'b1; req_left = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_bit("t6_disabled_valid", u_if.test_valid, 1'b0);
    end
    req_left = 1'b0; play_en = 1'b1;
    tick(); tick();
    check_bit("t6_reenable_valid", u_if.test_valid, 1'b0);
    check_bit("t6_reenable_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/move_test_sequencer.md
Name: move_test_sequencer

Overview:
Sequential successor to the combinational test-position generator.
- Latches movement requests (drop tick, left, right, rotate CW, rotate CCW) into pending flags.
- Serialises pending requests by fixed priority and proposes one test position/rotation at a time to the collision checker over a valid/done handshake.
- On fit, commits the test pose to the current pose. On a failed drop, emits a lock pulse. On a failed rotate, optionally retries with horizontal wall-kick offsets.
- Sits between the input debouncers/drop timer and the board collision checker in the play datapath.

Parameters:
X_BITS, 4, width of x position
Y_BITS, 5, width of y position
ROT_BITS, 2, width of rotation index
NUM_KICKS, 3, rotate attempts per request (1..3); kick dx sequence 0, -1, +1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
play_en  in  1  1 = play mode; 0 = sequencer held idle
spawn  in  1  load new piece pose (pulse)
spawn_x  in  X_BITS  spawn x
spawn_y  in  Y_BITS  spawn y
drop_tick  in  1  gravity request (pulse)
req_left  in  1  move-left request (pulse)
req_right  in  1  move-right request (pulse)
req_rot_cw  in  1  rotate +1 request (pulse)
req_rot_ccw  in  1  rotate -1 request (pulse)
test_valid  out  1  test pose valid, held until chk_done
test_pos_x  out  X_BITS  proposed x
test_pos_y  out  Y_BITS  proposed y
test_rot  out  ROT_BITS  proposed rotation
chk_done  in  1  checker result valid (single cycle)
chk_fit  in  1  1 = proposed pose fits; sampled only with chk_done
cur_pos_x  out  X_BITS  committed x
cur_pos_y  out  Y_BITS  committed y
cur_rot  out  ROT_BITS  committed rotation
lock_pulse  out  1  one-cycle pulse: drop failed, piece must lock
busy  out  1  state != IDLE

Behaviour:
Reset values:
- Async assert: all outputs 0, pending flags 0, state IDLE.

Pending flags:
- One flag per request type; set on the clk edge after the input pulse.
- Cleared when that request is selected in IDLE.
- A new pulse arriving on the same edge the flag is cleared re-sets the flag, so the request is not lost.
- Repeated pulses while a flag is already set merge into one request.

State machine:
- IDLE: if any flag is set, select by priority drop > left > right > rot_cw > rot_ccw, compute the test pose, and go to TEST on the next edge.
  - drop: y+1
  - left: x-1
  - right: x+1
  - rot_cw: rot+1
  - rot_ccw: rot-1
- TEST: test_valid=1; test pose held stable. Wait indefinitely for chk_done.
  - chk_done & chk_fit -> COMMIT.
  - chk_done & !chk_fit:
    - rotate with kick index < NUM_KICKS-1: increment kick index, recompute test_pos_x = cur_pos_x + next dx, stay in TEST with test_valid deasserted for exactly 1 cycle (re-issue).
    - drop: lock_pulse=1 for one cycle -> IDLE.
    - otherwise: discard -> IDLE.
- COMMIT: cur_* <= test_* ; -> IDLE.

Latency:
- Request pulse to test_valid: 2 cycles.
- chk_done(fit) to cur_* updated: 1 edge.

Arithmetic:
- All arithmetic is modulo 2^width. Left at x=0 proposes x=2^X_BITS-1.
- The sequencer performs no board-range check; the checker must reject out-of-board poses.

spawn:
- Overrides all other activity in any state, including mid-TEST.
- cur_pos <= spawn_x/y, cur_rot <= 0.
- Clears all pending flags and the kick index; state -> IDLE; lock_pulse not asserted.
- A request pulse coincident with spawn is dropped.

play_en=0:
- State -> IDLE; pending flags cleared and flag setting disabled; test_valid=0; cur_* held.

Checker handshake:
- chk_done while not in TEST is ignored.

Optional Feature:
WALL_KICK_EN
- Defined: rotate failure retries with kick offsets as above, up to NUM_KICKS attempts.
- Undefined: NUM_KICKS is treated as 1; a rotate fail is discarded immediately and the kick index logic is not synthesised.

Decomposition:
Shared package:
- Board dimensions and pose width constants (X_BITS, Y_BITS, ROT_BITS).
- Request-type encoding (REQ_DROP, REQ_LEFT, REQ_RIGHT, REQ_ROT_CW, REQ_ROT_CCW).
- State encoding (IDLE, TEST, COMMIT).
- Kick offset table.

Sub-module:
- One natural sub-module, move_req_pending: pending-flag register bank plus fixed-priority selector producing a one-hot grant.

Test Plan:
1. Reset, spawn x=4 y=0; drop_tick; checker responds done/fit after 3 cycles -> test_pos=(4,1,0); cur=(4,1,0) one edge later; lock_pulse=0.
2. cur=(4,20,0), drop_tick, checker done/no-fit -> exactly one lock_pulse cycle, cur unchanged, busy falls next cycle.
3. req_left and req_rot_cw in the same cycle, both fit -> two serialised tests: first (3,y,0), then (3,y,1); final cur=(3,y,1).
4. WALL_KICK_EN, NUM_KICKS=3, cur=(0,5,1), req_rot_cw; checker no-fit, no-fit, fit -> tests x=0, x=15, x=1 with rot=2; final cur=(1,5,2).
5. Mid-TEST spawn x=4 y=0 with pending right -> test_valid drops, cur=(4,0,0), pending cleared; a late chk_done is ignored.
6. Async rst_n low mid-TEST -> all outputs 0 immediately; req_left held pulsing with play_en=0 -> no test_valid ever asserted.
